dmem_load_unit: RTL
===================

# dmem_load_unit

Read-side companion to the data-memory write port. It accepts RISC-V load requests from the core and issues synchronous reads to the four byte-lane data banks. It aligns and sign- or zero-extends the returned bytes and returns one 32-bit result per request over a valid/ready handshake. Misaligned loads that span two words are split into two consecutive bank reads.

## Interface
- DEPTH, 128, words per byte-lane bank
- AW, 7, word-index width; must equal log2(DEPTH)
- REGION, 16'h0800, required value of req_addr[31:16] for a data access
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  load request present
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid and req_ready are both high
- req_addr  input  32  byte address
- req_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts the response
- rsp_data  output  32  extended load result
- rsp_err  output  1  region miss or illegal funct3
- mem_rd_en  output  1  bank read strobe
- mem_rd_idx  output  AW  word index for the bank read
- mem_rd_data  input  32  {lane3,lane2,lane1,lane0}; valid the cycle after mem_rd_en; little-endian, lane0 holds byte offset 0

## Operation
- States: IDLE, ISSUE, CAP0, CAP1, RESP.
- On accept, latch the following:
  - addr
  - funct3
  - W = addr[AW+1:2]
  - off = addr[1:0]
  - cross = (LW and off≠0) or (LH/LHU and off=3)
- Bits addr[15:AW+2] are ignored, so aliasing is permitted.
- Error check at accept: addr[31:16]≠REGION or funct3 ∈ {011,110,111}.
  - Go IDLE→RESP with rsp_err=1 and rsp_data=0.
  - No bank read is issued.
- Normal path: IDLE→ISSUE.
- ISSUE:
  - mem_rd_en=1, mem_rd_idx=W.
  - Go to CAP0.
- CAP0:
  - Capture mem_rd_data into lo.
  - If cross: mem_rd_en=1, mem_rd_idx=(W+1) mod DEPTH, go to CAP1.
  - Otherwise: hi=0, form the result, go to RESP.
- CAP1: capture mem_rd_data into hi, form the result, go to RESP.
- Result formation:
  - s = ({hi,lo} >> 8·off)[31:0]
  - LB: sext(s[7:0]). LBU: zext(s[7:0]).
  - LH: sext(s[15:0]). LHU: zext(s[15:0]).
  - LW: s.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are registered and held stable.
  - Leave RESP when rsp_ready=1, returning to IDLE on the next edge.
- mem_rd_en is decoded from state; it is never high in IDLE, RESP, or CAP1.
- The unit has no outstanding-request queue: exactly one request is in flight.

## Timing
- Request accepted at edge T. Response timing:
  - Aligned or non-crossing load: rsp_valid first high in cycle T+3.
  - Crossing load: rsp_valid first high in cycle T+4.
  - Error: rsp_valid first high in cycle T+1.
- Minimum request spacing is 4 cycles for aligned loads and 5 for crossing loads, given rsp_ready=1.
- Backpressure: while rsp_ready=0, rsp_valid, rsp_data and rsp_err stay unchanged and req_ready=0.
- If rsp_ready is high in the first RESP cycle, RESP lasts exactly one cycle.
- Reset values: state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, mem_rd_idx=0, mem_rd_en=0. req_ready=1 once reset deasserts.
- Reset mid-operation aborts the request:
  - No response is ever produced.
  - Read data returned after reset is ignored.
- Index wrap: a crossing load at W=DEPTH-1 reads index DEPTH-1 then index 0.

## Test plan
Bank model preload: word0=0x11719195, word1=0x16032976, word2=0x11759426. All requests below use rsp_ready=1 unless stated.
- **Aligned LW:** LW 0x0800_0000 -> one mem_rd_en with idx 0; rsp_data=0x11719195, rsp_err=0, at T+3.
- **Byte and halfword extraction:**
  - LB 0x0800_0001 -> 0xFFFFFF91. LBU at the same address -> 0x00000091.
  - LH 0x0800_0002 -> 0x00001171.
  - LHU 0x0800_0004 -> 0x00002976.
- **Crossing loads:**
  - LH 0x0800_0003 -> two reads (idx 0, then idx 1) on consecutive cycles; rsp_data=0x00007611 at T+4.
  - LW 0x0800_0006 -> reads idx 1, then idx 2; rsp_data=0x94261603.
- **Errors:**
  - LW 0x0001_0000 -> rsp_err=1, rsp_data=0 at T+1, no mem_rd_en.
  - funct3=011 at 0x0800_0000 -> same error response.
- **Backpressure and back-to-back:**
  - Hold rsp_ready=0 for 3 cycles -> response stable and req_ready=0 throughout.
  - Then LW 0x0800_0008 presented continuously -> accepted in the cycle after RESP exits; returns 0x11759426.
- **Wrap and reset:**
  - LW 0x0800_01FD -> reads idx 127, then idx 0.
  - Assert rst during CAP0 of any load -> all outputs at reset values, no rsp_valid.
  - After reset, a new LW 0x0800_0000 returns 0x11719195 normally.

Source files
------------

// File: rtl/dmem_load_unit.sv
// Load unit: accepts one load at a time, reads the byte-lane banks, aligns and extends the result.
// Latency: response 2 cycles after accept (3 when the load spans two words), 0 for an error.
// Backpressure: one request in flight; req_ready drops until the held response is taken.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_valid/req_ready               load request handshake (ready only in IDLE)
//   req_addr, req_funct3              byte address and RISC-V load type
//   rsp_valid/rsp_ready               response handshake
//   rsp_data, rsp_err                 extended load result, region/funct3 error flag
//   mem_rd_en, mem_rd_idx             bank read strobe and word index
//   mem_rd_data                       {lane3..lane0} read data, valid the cycle after mem_rd_en
module dmem_load_unit #(
    parameter int          DEPTH  = 128,
    parameter int          AW     = 7,
    parameter logic [15:0] REGION = 16'h0800
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    input  logic [2:0]    req_funct3,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_idx,
    input  logic [31:0]   mem_rd_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CAP0  = 3'd2,
        CAP1  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_t        state;
    state_t        state_nxt;

    // Request context latched on accept
    logic [AW-1:0] w_q;
    logic [1:0]    off_q;
    logic [2:0]    f3_q;
    logic          cross_q;
    logic [31:0]   lo_q;

    logic [AW-1:0] w_inc;
    logic          accept;
    logic          req_bad;
    logic          req_cross;
    logic          load_lo;
    logic          load_rsp;
    logic [31:0]   rsp_data_nxt;
    logic          rsp_err_nxt;

    // Address bits between the word index and the region tag alias onto the same words.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^req_addr[15:AW+2];

    // Shift the two-word window down to the addressed byte, then extend by load type.
    function automatic logic [31:0] form_result(
        input logic [2:0]  f3,
        input logic [1:0]  off,
        input logic [31:0] hi,
        input logic [31:0] lo
    );
        logic [63:0] pair;
        logic [31:0] s;
        logic [31:0] r;
        pair = {hi, lo} >> {off, 3'b000};
        s    = pair[31:0];
        case (f3)
            F3_LB:   r = {{24{s[7]}}, s[7:0]};
            F3_LBU:  r = {24'h0, s[7:0]};
            F3_LH:   r = {{16{s[15]}}, s[15:0]};
            F3_LHU:  r = {16'h0, s[15:0]};
            F3_LW:   r = s;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always_comb begin
        req_bad = (req_addr[31:16] != REGION) ||
                  (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
        req_cross = ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00)) ||
                    (((req_funct3 == F3_LH) || (req_funct3 == F3_LHU)) && (req_addr[1:0] == 2'b11));
    end

    // Second word of a crossing load wraps from the last bank word back to word 0.
    assign w_inc = (w_q == AW'(DEPTH - 1)) ? '0 : w_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_rd_idx   = '0;
        accept       = 1'b0;
        load_lo      = 1'b0;
        load_rsp     = 1'b0;
        rsp_data_nxt = 32'h0;
        rsp_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_bad) begin
                        // Errors skip the banks entirely and answer with zero data.
                        load_rsp    = 1'b1;
                        rsp_err_nxt = 1'b1;
                        state_nxt   = RESP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                mem_rd_en  = 1'b1;
                mem_rd_idx = w_q;
                state_nxt  = CAP0;
            end
            CAP0: begin
                load_lo = 1'b1;
                if (cross_q) begin
                    mem_rd_en  = 1'b1;
                    mem_rd_idx = w_inc;
                    state_nxt  = CAP1;
                end else begin
                    load_rsp     = 1'b1;
                    rsp_data_nxt = form_result(f3_q, off_q, 32'h0, mem_rd_data);
                    state_nxt    = RESP;
                end
            end
            CAP1: begin
                load_rsp     = 1'b1;
                rsp_data_nxt = form_result(f3_q, off_q, mem_rd_data, lo_q);
                state_nxt    = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q      <= '0;
            off_q    <= 2'b00;
            f3_q     <= 3'b000;
            cross_q  <= 1'b0;
            lo_q     <= 32'h0;
            rsp_data <= 32'h0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                w_q     <= req_addr[AW+1:2];
                off_q   <= req_addr[1:0];
                f3_q    <= req_funct3;
                cross_q <= req_cross;
            end
            if (load_lo) begin
                lo_q <= mem_rd_data;
            end
            // Response registers only change when a new result is formed, so they
            // stay stable throughout RESP regardless of rsp_ready.
            if (load_rsp) begin
                rsp_data <= rsp_data_nxt;
                rsp_err  <= rsp_err_nxt;
            end
        end
    end

endmodule
